// File: rtl/oam_pkg.sv
// Shared definitions for the OAM controller: scan/clear FSM states and default sizing.
package oam_pkg;

  localparam int unsigned OAM_NUM_SPRITES_DEF = 64;
  localparam int unsigned OAM_HALF_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } oam_state_e;

endpackage

// File: rtl/oam_bank.sv
// One half of the OAM: DEPTH x W RAM with one write port and two registered read ports.
module oam_bank
  import oam_pkg::*;
#(
  parameter int unsigned DEPTH = OAM_NUM_SPRITES_DEF,
  parameter int unsigned W     = OAM_HALF_W_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] ra_addr_i,
  output logic [W-1:0]  ra_data_o,
  input  logic          rb_en_i,
  input  logic [AW-1:0] rb_addr_i,
  output logic [W-1:0]  rb_data_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] ra_data_q;
  logic [W-1:0] rb_data_q;

  // Storage is deliberately left out of reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read registers sample pre-write contents; port B holds its value while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_data_q <= {W{1'b0}};
      rb_data_q <= {W{1'b0}};
    end else begin
      ra_data_q <= mem_q[ra_addr_i];
      if (rb_en_i) begin
        rb_data_q <= mem_q[rb_addr_i];
      end
    end
  end

  assign ra_data_o = ra_data_q;
  assign rb_data_o = rb_data_q;

endmodule

// File: rtl/oam_ctrl.sv
// OAM controller: half-entry writes, registered random read, handshaked sequential scan.
// Optional bulk clear is built only when OAM_CLEAR_EN is defined.
module oam_ctrl
  import oam_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = OAM_NUM_SPRITES_DEF,
  parameter int unsigned HALF_W      = OAM_HALF_W_DEF,
  localparam int unsigned AW         = $clog2(NUM_SPRITES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [AW:0]         write_addr,
  input  logic [HALF_W-1:0]   write_data,
  input  logic [AW-1:0]       read_addr,
  output logic [2*HALF_W-1:0] read_data,
  input  logic                scan_start,
  input  logic                scan_ready,
  output logic                scan_valid,
  output logic [2*HALF_W-1:0] scan_data,
  output logic [AW-1:0]       scan_index,
  output logic                scan_last,
  output logic                busy,
  input  logic                clear_start
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);

  oam_state_e        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              scan_ren_s;
  logic              clr_we_s;
  logic              clear_req_s;
  logic              lo_we_s, hi_we_s;
  logic [AW-1:0]     bank_waddr_s;
  logic [HALF_W-1:0] bank_wdata_s;
  logic [HALF_W-1:0] lo_ra_s, hi_ra_s, lo_rb_s, hi_rb_s;

`ifdef OAM_CLEAR_EN
  assign clear_req_s = clear_start;
`else
  logic clear_start_unused_s;
  assign clear_start_unused_s = clear_start;
  assign clear_req_s          = 1'b0;
`endif

  // FSM state and shared scan/clear index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; clear takes priority over scan when both are requested.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scan_ren_s = 1'b0;
    clr_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req_s) begin
          state_d = CLEAR;
          idx_d   = {AW{1'b0}};
        end else if (scan_start) begin
          state_d = FETCH;
          idx_d   = {AW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        scan_ren_s = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (scan_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
            idx_d   = idx_q + AW'(1);
          end
        end else begin
          state_d = PRESENT;
        end
      end
      CLEAR: begin
        clr_we_s = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = {AW{1'b0}};
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {AW{1'b0}};
      end
    endcase
  end

  // Write port mux: clear owns both banks and masks external writes.
  always_comb begin
    if (clr_we_s) begin
      lo_we_s      = 1'b1;
      hi_we_s      = 1'b1;
      bank_waddr_s = idx_q;
      bank_wdata_s = {HALF_W{1'b0}};
    end else begin
      lo_we_s      = write_enable & ~write_addr[0];
      hi_we_s      = write_enable &  write_addr[0];
      bank_waddr_s = write_addr[AW:1];
      bank_wdata_s = write_data;
    end
  end

  oam_bank #(.DEPTH(NUM_SPRITES), .W(HALF_W)) u_bank_lo (
    .clk       (clk),
    .reset     (reset),
    .we_i      (lo_we_s),
    .waddr_i   (bank_waddr_s),
    .wdata_i   (bank_wdata_s),
    .ra_addr_i (read_addr),
    .ra_data_o (lo_ra_s),
    .rb_en_i   (scan_ren_s),
    .rb_addr_i (idx_q),
    .rb_data_o (lo_rb_s)
  );

  oam_bank #(.DEPTH(NUM_SPRITES), .W(HALF_W)) u_bank_hi (
    .clk       (clk),
    .reset     (reset),
    .we_i      (hi_we_s),
    .waddr_i   (bank_waddr_s),
    .wdata_i   (bank_wdata_s),
    .ra_addr_i (read_addr),
    .ra_data_o (hi_ra_s),
    .rb_en_i   (scan_ren_s),
    .rb_addr_i (idx_q),
    .rb_data_o (hi_rb_s)
  );

  assign read_data  = {hi_ra_s, lo_ra_s};
  assign scan_data  = {hi_rb_s, lo_rb_s};
  assign scan_index = idx_q;
  assign scan_valid = (state_q == PRESENT);
  assign scan_last  = (state_q == PRESENT) && (idx_q == LAST_IDX);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_oam_ctrl.sv
// Self-checking bench for oam_ctrl: vector table for write/read, scoreboard for scans and sweeps.
module tb_oam_ctrl;

  localparam int N  = 64;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_enable;
  logic [6:0]    write_addr;
  logic [15:0]   write_data;
  logic [5:0]    read_addr;
  logic [31:0]   read_data;
  logic          scan_start;
  logic          scan_ready;
  logic          scan_valid;
  logic [31:0]   scan_data;
  logic [5:0]    scan_index;
  logic          scan_last;
  logic          busy;
  logic          clear_start;

  oam_ctrl #(.NUM_SPRITES(N), .HALF_W(HW)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .scan_start   (scan_start),
    .scan_ready   (scan_ready),
    .scan_valid   (scan_valid),
    .scan_data    (scan_data),
    .scan_index   (scan_index),
    .scan_last    (scan_last),
    .busy         (busy),
    .clear_start  (clear_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [6:0]  waddr;
    logic [15:0] wdata;
    logic [5:0]  raddr;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          idx;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [N];
  exp_t        sb_q [$];
  vec_t        vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [15:0] d);
    write_enable = 1'b1;
    write_addr   = addr[6:0];
    write_data   = d;
    tick();
    write_enable = 1'b0;
    if (addr[0]) mem_m[addr >> 1][31:16] = d;
    else         mem_m[addr >> 1][15:0]  = d;
  endtask

  task automatic push_scan_from(input int first);
    exp_t e;
    for (int i = first; i < N; i++) begin
      e.data = mem_m[i];
      e.idx  = i;
      sb_q.push_back(e);
    end
  endtask

  // Consumes scan output (scan_ready expected high) until busy drops.
  task automatic drain_scan(input string tag, output int cyc);
    exp_t e;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      if (scan_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra: got entry %0d expected none", tag, scan_index);
        end else begin
          e = sb_q.pop_front();
          chk({tag, "_data"},  scan_data, e.data);
          chk({tag, "_index"}, 32'(scan_index), 32'(e.idx));
          chk({tag, "_last"},  32'(scan_last), (e.idx == N - 1) ? 32'd1 : 32'd0);
        end
      end
      tick();
      cyc++;
    end
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic read_sweep(input string tag);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      read_addr = 6'(i);
      e.data = mem_m[i];
      e.idx  = i;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      chk(tag, read_data, e.data);
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] held;

    vt[0] = '{1'b1, 7'd0, 16'h1234, 6'd0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 7'd1, 16'h5678, 6'd0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 7'd2, 16'h9876, 6'd0, 1'b0, 32'h0};
    vt[3] = '{1'b1, 7'd3, 16'h5432, 6'd0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 7'd0, 16'h0000, 6'd1, 1'b1, 32'h54329876};
    vt[5] = '{1'b0, 7'd0, 16'h0000, 6'd0, 1'b1, 32'h56781234};
    vt[6] = '{1'b1, 7'd1, 16'hAAAA, 6'd0, 1'b1, 32'h56781234};
    vt[7] = '{1'b0, 7'd0, 16'h0000, 6'd0, 1'b1, 32'hAAAA1234};
    vt[8] = '{1'b1, 7'd2, 16'h0001, 6'd1, 1'b1, 32'h54329876};
    vt[9] = '{1'b0, 7'd0, 16'h0000, 6'd1, 1'b1, 32'h54320001};

    reset = 1'b1; write_enable = 1'b0; write_addr = 7'd0; write_data = 16'd0;
    read_addr = 6'd0; scan_start = 1'b0; scan_ready = 1'b0; clear_start = 1'b0;
    tick();
    tick();
    chk("rst_read_data",  read_data, 32'd0);
    chk("rst_scan_data",  scan_data, 32'd0);
    chk("rst_scan_index", 32'(scan_index), 32'd0);
    chk("rst_scan_valid", 32'(scan_valid), 32'd0);
    chk("rst_scan_last",  32'(scan_last), 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Table: half writes, registered read, read-old-data on same-cycle write.
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      write_enable = vt[i].we;
      write_addr   = vt[i].waddr;
      write_data   = vt[i].wdata;
      read_addr    = vt[i].raddr;
      if (vt[i].chk) begin
        e.data = vt[i].exp;
        e.idx  = i;
        sb_q.push_back(e);
      end
      tick();
      if (vt[i].chk) begin
        e = sb_q.pop_front();
        chk($sformatf("vec%0d_read", e.idx), read_data, e.data);
      end
    end
    write_enable = 1'b0;

    for (int i = 0; i < 2 * N; i++) wr(i, 16'($urandom));

    // Full scan with scan_ready held high.
    scan_ready = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    push_scan_from(0);
    drain_scan("scan_full", cyc);
    chk("scan_full_cycles", 32'(cyc), 32'd128);

    // Stall in PRESENT at entry 0; writes to held entry and to entry 1.
    scan_ready = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    cyc = 0;
    while (scan_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("stall_valid", 32'(scan_valid), 32'd1);
    chk("stall_index0", 32'(scan_index), 32'd0);
    chk("stall_data0", scan_data, mem_m[0]);
    held = mem_m[0];
    for (int k = 0; k < 5; k++) begin
      if (k == 1)      wr(0, 16'hDEAD);
      else if (k == 2) wr(2, 16'hBEEF);
      else             tick();
      chk("stall_hold_data",  scan_data, held);
      chk("stall_hold_index", 32'(scan_index), 32'd0);
      chk("stall_hold_valid", 32'(scan_valid), 32'd1);
    end
    sb_q.push_back('{held, 0});
    push_scan_from(1);
    scan_ready = 1'b1;
    drain_scan("scan_stall", cyc);

    // Reset in the middle of a scan at index 10.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    cyc = 0;
    while (!(scan_valid === 1'b1 && scan_index == 6'd10) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("mid_reach_idx10", 32'(scan_index), 32'd10);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(scan_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_index", 32'(scan_index), 32'd0);
    chk("mid_rst_data",  scan_data, 32'd0);
    chk("mid_rst_last",  32'(scan_last), 32'd0);
    chk("mid_rst_rdata", read_data, 32'd0);
    reset = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    push_scan_from(0);
    drain_scan("scan_after_rst", cyc);

    // Bulk clear.
    for (int i = 0; i < 2 * N; i++) wr(i, 16'hFFFF);
`ifdef OAM_CLEAR_EN
    clear_start = 1'b1;
    scan_start  = 1'b1;
    tick();
    clear_start = 1'b0;
    scan_start  = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      write_enable = 1'b1;
      write_addr   = 7'($urandom_range(0, 2 * N - 1));
      write_data   = 16'h5555;
      if (scan_valid === 1'b1) chk("clr_no_scan", 32'(scan_valid), 32'd0);
      tick();
      cyc++;
    end
    write_enable = 1'b0;
    chk("clr_busy_cycles", 32'(cyc), 32'd64);
    for (int i = 0; i < N; i++) mem_m[i] = 32'd0;
`else
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("noclr_busy0", 32'(busy), 32'd0);
    tick();
    chk("noclr_busy1", 32'(busy), 32'd0);
`endif
    read_sweep("clr_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_ctrl.md
OAM_CTRL -- requirements
Module: oam_ctrl

Interface
REQ-001 Parameter NUM_SPRITES, default 64: number of OAM entries; power of two, at least 2.
REQ-002 Parameter HALF_W, default 16: width of one half-entry; an entry is 2*HALF_W bits.
REQ-003 Port clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port write_enable  in  1  write strobe for write_data.
REQ-006 Port write_addr  in  $clog2(NUM_SPRITES)+1  half-entry address; bit 0 selects low (0) or high (1) half, upper bits select the entry.
REQ-007 Port write_data  in  HALF_W  half-entry write data.
REQ-008 Port read_addr  in  $clog2(NUM_SPRITES)  entry address for the random read port.
REQ-009 Port read_data  out  2*HALF_W  {high half, low half} of entry read_addr.
REQ-010 Port scan_start  in  1  pulse that starts a sequential scan of all entries.
REQ-011 Port scan_ready  in  1  consumer accepts the current scan entry.
REQ-012 Port scan_valid  out  1  scan_data and scan_index are valid.
REQ-013 Port scan_data  out  2*HALF_W  entry under scan.
REQ-014 Port scan_index  out  $clog2(NUM_SPRITES)  index of scan_data.
REQ-015 Port scan_last  out  1  scan_index equals NUM_SPRITES-1 while scan_valid is high.
REQ-016 Port busy  out  1  scan or clear in progress.
REQ-017 Port clear_start  in  1  pulse that zeroes all entries; present regardless of configuration.

Function
REQ-018 Write: write_data lands in the addressed half on the edge where write_enable is high; the other half is unchanged.
REQ-019 Random read: read_data is registered, 1-cycle latency; a same-cycle write to the read entry returns old data.
REQ-020 FSM states: IDLE, FETCH, PRESENT, CLEAR.
REQ-021 IDLE -> FETCH on scan_start, with the index set to 0; scan_start outside IDLE is ignored.
REQ-022 FETCH issues the scan read for the current index, then enters PRESENT the next cycle with scan_valid high.
REQ-023 In PRESENT, scan_data/scan_index stay stable until scan_valid && scan_ready; the handshake goes to IDLE if scan_last, else increments the index and goes to FETCH.
REQ-024 A write during a scan to an entry not yet fetched is visible in the scan; the entry held in PRESENT is not updated.
REQ-025 busy is high in FETCH, PRESENT and CLEAR, and low in IDLE.
REQ-026 If scan_start and clear_start are asserted together in IDLE, clear wins.

Reset
REQ-027 reset forces IDLE, scan_valid=0, scan_last=0, busy=0, scan_index=0, scan_data=0 and read_data=0 on the next edge, aborting any scan or clear mid-operation.
REQ-028 Memory contents are not affected by reset.

Configuration
REQ-029 Macro OAM_CLEAR_EN: when defined, clear_start in IDLE enters CLEAR.
- CLEAR writes zero to both halves of one entry per cycle, indices 0..NUM_SPRITES-1.
- CLEAR returns to IDLE after exactly NUM_SPRITES cycles.
- write_enable is ignored during CLEAR.
REQ-030 When OAM_CLEAR_EN is undefined, clear_start is ignored and CLEAR is unreachable.

Structure
REQ-031 Package oam_pkg holds the FSM state enum and the default NUM_SPRITES/HALF_W constants.
REQ-032 Sub-module oam_bank is a simple dual-port RAM (one write port, one registered read port), NUM_SPRITES x HALF_W.
- Two oam_bank instances: low half and high half.
- The random read port and the scanner share read access through a second read port per bank, or one bank pair per port; the write port is replicated.

Verification
REQ-033 Write addr 0..3 with 0x1234, 0x5678, 0x9876, 0x5432, then read_addr=1 -> read_data=0x54329876 one cycle later.
REQ-034 scan_start, scan_ready held high -> NUM_SPRITES entries in index order, 2 cycles each; scan_last only at index 63; busy low after.
REQ-035 scan_ready low for 5 cycles in PRESENT -> scan_data/scan_index unchanged.
- Write to the held entry in that window -> value not reflected.
- Write to entry index+1 -> new value scanned next.
REQ-036 Reset asserted mid-scan at index 10 -> next cycle scan_valid=0 and busy=0; new scan_start restarts at index 0.
REQ-037 With OAM_CLEAR_EN: fill all entries with 0xFFFFFFFF, pulse clear_start -> busy for 64 cycles, then every read returns 0; concurrent write_enable has no effect. Without OAM_CLEAR_EN: busy stays 0 and contents remain.
